// File: rtl/string_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : string_reader_pkg
// Description : Shared character codes, line-reader state encodings and a
//               baud-divisor helper for the serial console line reader.
//               The character codes and state encodings are shared with the
//               line transmitter.
// Revision    : 1.0  initial release
// ============================================================================
package string_reader_pkg;

  localparam logic [7:0] CHAR_LF  = 8'h0A;
  localparam logic [7:0] CHAR_CR  = 8'h0D;
  localparam logic [7:0] CHAR_BS  = 8'h08;
  localparam logic [7:0] CHAR_NUL = 8'h00;

  // Line reader states: collecting characters, or presenting a finished line
  localparam logic [0:0] ST_RECV = 1'b0;
  localparam logic [0:0] ST_HOLD = 1'b1;

  // Clock cycles per serial bit; clk_mhz is the system clock in MHz
  function automatic int baud_cycles(input int clk_mhz, input int baud);
    return (clk_mhz * 1000000) / baud;
  endfunction

endpackage
`default_nettype wire

// File: rtl/string_reader_uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : string_reader_uart_rx
// Description : 8N1 UART receiver. Synchronises the pin, samples each bit at
//               its centre (LSB first) and presents the byte with a
//               valid/ready handshake once a good stop bit is seen.
// Ports       : clk, rst_n (async active-low), rx_pin (serial in),
//               rx_data[7:0], rx_data_valid (out), rx_data_ready (in)
// Revision    : 1.0  initial release
// ============================================================================
module string_reader_uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx_pin,
  output logic [7:0] rx_data,
  output logic       rx_data_valid,
  input  logic       rx_data_ready
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  localparam logic [15:0] C_BIT_END  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] C_HALF_END = 16'(CLKS_PER_BIT / 2 - 1);

  logic [1:0]  state_q, state_d;
  logic [1:0]  sync_q, sync_d;
  logic [15:0] cyc_q, cyc_d;
  logic [2:0]  bit_q, bit_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        rx_s;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      sync_q  <= 2'b11;
      cyc_q   <= '0;
      bit_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q  <= sync_d;
      cyc_q   <= cyc_d;
      bit_q   <= bit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (!rx_s) state_d = S_START;
      // A start bit that is no longer low at its centre was a glitch
      S_START: if (cyc_q == C_HALF_END) state_d = rx_s ? S_IDLE : S_DATA;
      S_DATA:  if (cyc_q == C_BIT_END && bit_q == 3'd7) state_d = S_STOP;
      S_STOP:  if (cyc_q == C_BIT_END) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    sync_d  = {sync_q[0], rx_pin};
    cyc_d   = cyc_q + 16'd1;
    bit_d   = bit_q;
    data_d  = data_q;
    valid_d = valid_q & ~rx_data_ready;
    case (state_q)
      S_IDLE: cyc_d = '0;
      S_START: if (cyc_q == C_HALF_END) begin
        cyc_d = '0;
        bit_d = '0;
      end
      S_DATA: if (cyc_q == C_BIT_END) begin
        cyc_d  = '0;
        data_d = {rx_s, data_q[7:1]};
        bit_d  = bit_q + 3'd1;
      end
      S_STOP: if (cyc_q == C_BIT_END) begin
        cyc_d = '0;
        if (rx_s) valid_d = 1'b1;   // framing errors are silently dropped
      end
      default: cyc_d = '0;
    endcase
  end

  assign rx_data       = data_q;
  assign rx_data_valid = valid_q;

endmodule
`default_nettype wire

// File: rtl/string_reader.sv
`default_nettype none
// ============================================================================
// Module      : string_reader
// Description : Serial console receive side. Collects UART bytes into one
//               text line (first char in the top byte, null padded) and
//               presents it with a valid/ack handshake. CR is ignored, BS
//               deletes, LF terminates. Optional echo of accepted bytes is
//               enabled by defining STRING_READER_ECHO_EN.
// Ports       : clk, rst_n (async active-low), uart_rx (in), uart_tx (out),
//               line, line_len, line_valid, line_ack (in), overflow, overrun
// Revision    : 1.0  initial release
// ============================================================================
module string_reader
  import string_reader_pkg::*;
#(
  parameter int CLK_FRE   = 50,
  parameter int BAUD_RATE = 115200,
  parameter int MAX_CHARS = 81
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           uart_rx,
  output logic                           uart_tx,
  output logic [MAX_CHARS*8-1:0]         line,
  output logic [$clog2(MAX_CHARS+1)-1:0] line_len,
  output logic                           line_valid,
  input  logic                           line_ack,
  output logic                           overflow,
  output logic                           overrun
);

  localparam int LEN_W = $clog2(MAX_CHARS + 1);
  localparam int C_CLKS_PER_BIT = baud_cycles(CLK_FRE, BAUD_RATE);

  logic [7:0] rx_data;
  logic       rx_valid;

  string_reader_uart_rx #(.CLKS_PER_BIT(C_CLKS_PER_BIT)) u_rx (
    .clk           (clk),
    .rst_n         (rst_n),
    .rx_pin        (uart_rx),
    .rx_data       (rx_data),
    .rx_data_valid (rx_valid),
    .rx_data_ready (1'b1)
  );

  logic [0:0]             state_q, state_d;
  logic [MAX_CHARS*8-1:0] line_q, line_d;
  logic [LEN_W-1:0]       len_q, len_d;
  logic                   ovf_q, ovf_d;
  logic                   overrun_q, overrun_d;
  logic                   rx_plain, has_room;

  assign rx_plain = (rx_data != CHAR_CR) && (rx_data != CHAR_LF) && (rx_data != CHAR_BS);
  assign has_room = (len_q < LEN_W'(MAX_CHARS));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_RECV;
      line_q    <= '0;
      len_q     <= '0;
      ovf_q     <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      line_q    <= line_d;
      len_q     <= len_d;
      ovf_q     <= ovf_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RECV: if (rx_valid && rx_data == CHAR_LF) state_d = ST_HOLD;
      ST_HOLD: if (line_ack) state_d = ST_RECV;
      default: state_d = ST_RECV;
    endcase
  end

  // Line buffer: byte writes use a compare-per-slot loop so every slice is a
  // constant part-select.
  always_comb begin
    line_d    = line_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    overrun_d = 1'b0;
    if (state_q == ST_RECV) begin
      if (rx_valid && rx_plain) begin
        if (has_room) begin
          for (int i = 0; i < MAX_CHARS; i++)
            if (len_q == LEN_W'(i)) line_d[(MAX_CHARS-1-i)*8 +: 8] = rx_data;
          len_d = len_q + LEN_W'(1);
        end else begin
          ovf_d = 1'b1;
        end
      end else if (rx_valid && rx_data == CHAR_BS && len_q != '0) begin
        for (int i = 0; i < MAX_CHARS; i++)
          if (len_q == LEN_W'(i + 1)) line_d[(MAX_CHARS-1-i)*8 +: 8] = CHAR_NUL;
        len_d = len_q - LEN_W'(1);
      end
    end else begin
      // Held line is frozen; a byte arriving now is lost, even alongside ack
      overrun_d = rx_valid;
      if (line_ack) begin
        line_d = '0;
        len_d  = '0;
        ovf_d  = 1'b0;
      end
    end
  end

  always_comb begin
    line       = line_q;
    line_len   = len_q;
    line_valid = (state_q == ST_HOLD);
    overflow   = ovf_q & (state_q == ST_HOLD);
    overrun    = overrun_q;
  end

`ifdef STRING_READER_ECHO_EN
  localparam logic [15:0] C_TX_BIT_END = 16'(C_CLKS_PER_BIT - 1);

  logic        tx_busy_q, tx_busy_d;
  logic [9:0]  tx_shift_q, tx_shift_d;
  logic [15:0] tx_cyc_q, tx_cyc_d;
  logic [3:0]  tx_bit_q, tx_bit_d;
  logic        echo_req;

  // Everything accepted in RECV is echoed except chars dropped for space
  assign echo_req = (state_q == ST_RECV) && rx_valid && !(rx_plain && !has_room);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_busy_q  <= 1'b0;
      tx_shift_q <= '1;
      tx_cyc_q   <= '0;
      tx_bit_q   <= '0;
    end else begin
      tx_busy_q  <= tx_busy_d;
      tx_shift_q <= tx_shift_d;
      tx_cyc_q   <= tx_cyc_d;
      tx_bit_q   <= tx_bit_d;
    end
  end

  // No queue: a byte arriving while a previous echo is on the wire is skipped
  always_comb begin
    tx_busy_d  = tx_busy_q;
    tx_shift_d = tx_shift_q;
    tx_cyc_d   = tx_cyc_q;
    tx_bit_d   = tx_bit_q;
    if (tx_busy_q) begin
      if (tx_cyc_q == C_TX_BIT_END) begin
        tx_cyc_d   = '0;
        tx_shift_d = {1'b1, tx_shift_q[9:1]};
        tx_bit_d   = tx_bit_q + 4'd1;
        if (tx_bit_q == 4'd9) tx_busy_d = 1'b0;
      end else begin
        tx_cyc_d = tx_cyc_q + 16'd1;
      end
    end else if (echo_req) begin
      tx_busy_d  = 1'b1;
      tx_shift_d = {1'b1, rx_data, 1'b0};
      tx_cyc_d   = '0;
      tx_bit_d   = '0;
    end
  end

  assign uart_tx = tx_busy_q ? tx_shift_q[0] : 1'b1;
`else
  assign uart_tx = 1'b1;
`endif

endmodule
`default_nettype wire

// File: tb/tb_string_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_string_reader
// Description : Self-checking bench for string_reader. Drives 8N1 serial
//               bytes, pushes the expected line to a scoreboard queue when
//               the terminating LF is sent and compares on line_valid.
// Revision    : 1.0  initial release
// ============================================================================
module tb_string_reader;

  localparam int MAXC = 8;
  localparam int LW   = MAXC * 8;
  localparam int LENW = $clog2(MAXC + 1);
  localparam int BITC = 8;   // 1 MHz / 125000 baud

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            uart_rx = 1'b1;
  logic            uart_tx;
  logic [LW-1:0]   line;
  logic [LENW-1:0] line_len;
  logic            line_valid;
  logic            line_ack = 1'b0;
  logic            overflow;
  logic            overrun;

  string_reader #(.CLK_FRE(1), .BAUD_RATE(125000), .MAX_CHARS(MAXC)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .uart_rx    (uart_rx),
    .uart_tx    (uart_tx),
    .line       (line),
    .line_len   (line_len),
    .line_valid (line_valid),
    .line_ack   (line_ack),
    .overflow   (overflow),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct { string txt; string exp; bit ovf; } vec_t;
  typedef struct { string exp; bit ovf; } exp_t;

  vec_t vecs[7];
  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   ov_cnt = 0, ov_long = 0, tx_low = 0;
  logic ov_prev = 1'b0;

  always @(negedge clk) begin
    if (overrun) ov_cnt++;
    if (overrun && ov_prev) ov_long++;
    ov_prev = overrun;
    if (uart_tx !== 1'b1) tx_low++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [LW-1:0] pack(input string s);
    logic [LW-1:0] v = '0;
    for (int i = 0; i < s.len(); i++) v[(MAXC-1-i)*8 +: 8] = s[i];
    return v;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    uart_rx = 1'b0;
    tick(BITC);
    for (int i = 0; i < 8; i++) begin
      uart_rx = b[i];
      tick(BITC);
    end
    uart_rx = 1'b1;
    tick(2 * BITC);
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic send_line(input string txt, input string exp, input bit ovf);
    exp_t e;
    e.exp = exp;
    e.ovf = ovf;
    sbq.push_back(e);
    send_str(txt);
  endtask

  // Wait for line_valid, pop the scoreboard and compare the presented line
  task automatic expect_line(input string tag);
    int   n = 0;
    exp_t e;
    while (!line_valid && n < 400) begin
      tick(1);
      n++;
    end
    total++;
    if (!line_valid) begin
      bad++;
      $display("FAIL %s_timeout: line_valid=0 want 1", tag);
      return;
    end
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL %s_sb_empty: got line, want none", tag);
      return;
    end
    e = sbq.pop_front();
    check({tag, "_len"},  LW'(line_len), LW'(e.exp.len()));
    check({tag, "_line"}, line, pack(e.exp));
    check({tag, "_ovf"},  LW'(overflow), LW'(e.ovf));
  endtask

  task automatic ack_line(input string tag);
    line_ack = 1'b1;
    tick(1);
    line_ack = 1'b0;
    check({tag, "_ack_valid"}, LW'(line_valid), '0);
    check({tag, "_ack_ovf"},   LW'(overflow), '0);
    check({tag, "_ack_len"},   LW'(line_len), '0);
    check({tag, "_ack_line"},  line, '0);
  endtask

  initial begin
    int ov0;
    int n;
    vecs[0] = '{"HI\015\n",             "HI",       1'b0};
    vecs[1] = '{"\n",                   "",         1'b0};
    vecs[2] = '{"ABX\010C\n",           "ABC",      1'b0};
    vecs[3] = '{"\010\010Q\n",          "Q",        1'b0};
    vecs[4] = '{"aaaaaaaaaaa\n",        "aaaaaaaa", 1'b1};
    vecs[5] = '{"12345678\n",           "12345678", 1'b0};
    vecs[6] = '{"123456789\010\n",      "1234567",  1'b1};

    tick(3);
    check("rst_valid",   LW'(line_valid), '0);
    check("rst_len",     LW'(line_len), '0);
    check("rst_line",    line, '0);
    check("rst_ovf",     LW'(overflow), '0);
    check("rst_overrun", LW'(overrun), '0);
    check("rst_tx",      LW'(uart_tx), LW'(1));
    rst_n = 1'b1;
    tick(2);

    // ack while nothing is presented has no effect
    line_ack = 1'b1;
    tick(3);
    line_ack = 1'b0;
    check("idle_ack_valid", LW'(line_valid), '0);

    for (int v = 0; v < 7; v++) begin
      send_line(vecs[v].txt, vecs[v].exp, vecs[v].ovf);
      expect_line($sformatf("vec%0d", v));
      ack_line($sformatf("vec%0d", v));
    end

    // Byte arriving while a line is held: one-cycle overrun, line frozen
    send_line("Y\n", "Y", 1'b0);
    expect_line("hold");
    ov0 = ov_cnt;
    send_byte("Z");
    tick(10);
    check("hold_overrun_cnt", LW'(ov_cnt - ov0), LW'(1));
    check("hold_overrun_len", LW'(ov_long), '0);
    check("hold_valid", LW'(line_valid), LW'(1));
    check("hold_line",  line, pack("Y"));
    check("hold_len",   LW'(line_len), LW'(1));

    // ack in the same cycle the byte is accepted: byte dropped
    ov0 = ov_cnt;
    fork
      send_byte("W");
      begin
        n = 0;
        while (dut.rx_valid !== 1'b1 && n < 300) begin
          tick(1);
          n++;
        end
        line_ack = 1'b1;
        tick(1);
        line_ack = 1'b0;
      end
    join
    tick(4);
    check("ackbyte_overrun", LW'(ov_cnt - ov0), LW'(1));
    check("ackbyte_valid",   LW'(line_valid), '0);
    send_line("K\n", "K", 1'b0);
    expect_line("after_ackbyte");
    ack_line("after_ackbyte");

    // Reset mid-line discards the partial line
    send_str("AB");
    rst_n = 1'b0;
    tick(1);
    check("mid_rst_len",   LW'(line_len), '0);
    check("mid_rst_line",  line, '0);
    check("mid_rst_valid", LW'(line_valid), '0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    send_line("C\n", "C", 1'b0);
    expect_line("post_rst");
    ack_line("post_rst");

    // Reset while a line is held
    send_line("HI\n", "HI", 1'b0);
    expect_line("hold_rst");
    rst_n = 1'b0;
    tick(1);
    check("hold_rst_valid", LW'(line_valid), '0);
    check("hold_rst_line",  line, '0);
    rst_n = 1'b1;
    tick(2);

    check("sb_drained", LW'(sbq.size()), '0);
`ifdef STRING_READER_ECHO_EN
    total++;
    if (tx_low == 0) begin
      bad++;
      $display("FAIL echo_activity: uart_tx low cycles=0 want >0");
    end
`else
    check("tx_idle", LW'(tx_low), '0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
